// File: rtl/dest_reg_hazard_unit.sv
// dest_reg_hazard_unit
//   Data-hazard unit for a 5-stage pipeline. It takes the EX-stage destination
//   (after the RegDst mux), RegWrite and MemRead. It keeps its own MEM and WB
//   copies of the destination, and checks them against the sources of the ID
//   and EX instructions. From those matches it produces the pipeline stall and
//   the EX operand forwarding selects.
//
//   Ports
//     Clk, Reset_n          rising-edge clock, asynchronous active-low reset
//     rs_id, rt_id          source register numbers of the ID instruction
//     use_rs_id, use_rt_id  ID instruction actually reads rs / rt
//     flush_ex              ID instruction is discarded (bubble into EX)
//     wr_ex                 destination of the EX instruction
//     regwrite_ex           EX instruction writes wr_ex
//     memread_ex            EX instruction is a load
//     stall                 hold PC and IF/ID, bubble ID/EX (combinational)
//     fwd_a, fwd_b          EX operand select: 00 RF, 10 MEM, 01 WB
//     stall_cnt             saturating count of stalled cycles
//
//   Parameters
//     FWD_EN          1: forward from MEM/WB. 0: interlock until the producer
//                     has retired.
//     RF_WRITE_FIRST  1: the RF writes in the first half-cycle, so a WB match
//                     needs no interlock.
module dest_reg_hazard_unit #(
  parameter int REG_AW         = 5,
  parameter int FWD_EN         = 1,
  parameter int RF_WRITE_FIRST = 1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [REG_AW-1:0]      rs_id,
  input  logic [REG_AW-1:0]      rt_id,
  input  logic                   use_rs_id,
  input  logic                   use_rt_id,
  input  logic                   flush_ex,
  input  logic [REG_AW-1:0]      wr_ex,
  input  logic                   regwrite_ex,
  input  logic                   memread_ex,
  output logic                   stall,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // EX-stage source copy and MEM/WB destination shadows.
  logic [REG_AW-1:0]      rs_q, rt_q, wr_m, wr_w;
  logic                   use_rs_q, use_rt_q, we_m, we_w;
  logic [STALL_CNT_W-1:0] cnt_q;

  logic id_ex_hit, id_m_hit, id_w_hit, stall_raw;

  // A source hits a producer only when both sides are live and the register
  // is not r0, which is hard-wired zero.
  function automatic logic hit(input logic use_b, input logic we_b,
                               input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] dst);
    return use_b & we_b & (src == dst) & (dst != '0);
  endfunction

  always_comb begin
    id_ex_hit = hit(use_rs_id, regwrite_ex, rs_id, wr_ex) |
                hit(use_rt_id, regwrite_ex, rt_id, wr_ex);
    id_m_hit  = hit(use_rs_id, we_m, rs_id, wr_m) |
                hit(use_rt_id, we_m, rt_id, wr_m);
    id_w_hit  = hit(use_rs_id, we_w, rs_id, wr_w) |
                hit(use_rt_id, we_w, rt_id, wr_w);

    stall_raw = 1'b0;
    if (FWD_EN != 0) begin
      // Only a load in EX cannot be forwarded in time.
      stall_raw = memread_ex & id_ex_hit;
    end else begin
      stall_raw = id_ex_hit | id_m_hit | ((RF_WRITE_FIRST == 0) & id_w_hit);
    end

    // A flushed ID instruction never needs to wait. Gating with Reset_n makes
    // the stall drop as soon as reset is asserted.
    stall = stall_raw & ~flush_ex & Reset_n;

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      // MEM holds the younger producer, so it wins over WB.
      if (hit(use_rs_q, we_m, rs_q, wr_m))      fwd_a = 2'b10;
      else if (hit(use_rs_q, we_w, rs_q, wr_w)) fwd_a = 2'b01;
      if (hit(use_rt_q, we_m, rt_q, wr_m))      fwd_b = 2'b10;
      else if (hit(use_rt_q, we_w, rt_q, wr_w)) fwd_b = 2'b01;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rs_q     <= '0;
      rt_q     <= '0;
      use_rs_q <= 1'b0;
      use_rt_q <= 1'b0;
      wr_m     <= '0;
      we_m     <= 1'b0;
      wr_w     <= '0;
      we_w     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // The shadows follow the real pipeline, which advances past a stall:
      // the stall only bubbles EX.
      wr_m <= wr_ex;
      we_m <= regwrite_ex;
      wr_w <= wr_m;
      we_w <= we_m;
      if (flush_ex || stall) begin
        use_rs_q <= 1'b0;
        use_rt_q <= 1'b0;
      end else begin
        rs_q     <= rs_id;
        rt_q     <= rt_id;
        use_rs_q <= use_rs_id;
        use_rt_q <= use_rt_id;
      end
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_dest_reg_hazard_unit.sv
// Bench for dest_reg_hazard_unit.
//   dut_a uses the default parameters (forwarding on).
//   dut_b uses FWD_EN=0, RF_WRITE_FIRST=1 and a 3-bit counter, so that
//   counter saturation can be reached quickly.
//   Both instances share the same inputs.
//   Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_dest_reg_hazard_unit;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [4:0] rs_id, rt_id, wr_ex;
  logic       use_rs_id, use_rt_id, flush_ex, regwrite_ex, memread_ex;

  logic        stall_a, stall_b;
  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  dest_reg_hazard_unit dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .flush_ex(flush_ex),
    .wr_ex(wr_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
    .stall(stall_a), .fwd_a(fa_a), .fwd_b(fb_a), .stall_cnt(cnt_a)
  );

  dest_reg_hazard_unit #(.FWD_EN(0), .RF_WRITE_FIRST(1), .STALL_CNT_W(3)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .flush_ex(flush_ex),
    .wr_ex(wr_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
    .stall(stall_b), .fwd_a(fa_b), .fwd_b(fb_b), .stall_cnt(cnt_b)
  );

  // Clock
  always #5 Clk = ~Clk;

  // One cycle of stimulus together with its expected outputs.
  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urs, urt, fl;
    logic [4:0] wr;
    logic       rw, mr;
    logic       st;
    logic [1:0] fa, fb;
    logic [15:0] cnt;
  } vec_t;

  // Expected queue entry: {stall, fwd_a, fwd_b, stall_cnt}.
  logic [20:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input string name,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic fl,
                              input logic [4:0] wr, input logic rw, input logic mr,
                              input logic st, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [15:0] cnt);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.fl = fl;
    v.wr = wr; v.rw = rw; v.mr = mr; v.st = st; v.fa = fa; v.fb = fb; v.cnt = cnt;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    rs_id = v.rs; rt_id = v.rt; use_rs_id = v.urs; use_rt_id = v.urt;
    flush_ex = v.fl; wr_ex = v.wr; regwrite_ex = v.rw; memread_ex = v.mr;
  endtask

  task automatic drive_idle();
    rs_id = '0; rt_id = '0; use_rs_id = 1'b0; use_rt_id = 1'b0;
    flush_ex = 1'b0; wr_ex = '0; regwrite_ex = 1'b0; memread_ex = 1'b0;
  endtask

  task automatic drive_random();
    rs_id = 5'($urandom_range(0, 31)); rt_id = 5'($urandom_range(0, 31));
    use_rs_id = 1'($urandom_range(0, 1)); use_rt_id = 1'($urandom_range(0, 1));
    flush_ex = 1'($urandom_range(0, 1)); wr_ex = 5'($urandom_range(0, 31));
    regwrite_ex = 1'($urandom_range(0, 1)); memread_ex = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard: pop the oldest expectation and compare it with the DUT
  // selected by sel (0 = dut_a, 1 = dut_b).
  task automatic check(input string name, input bit sel);
    logic [20:0] exp, act;
    if (sel) act = {stall_b, fa_b, fb_b, 13'd0, cnt_b};
    else     act = {stall_a, fa_a, fb_a, cnt_a};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got stall=%b fwd_a=%b fwd_b=%b cnt=%0d, expected stall=%b fwd_a=%b fwd_b=%b cnt=%0d",
                 name, act[20], act[19:18], act[17:16], act[15:0],
                 exp[20], exp[19:18], exp[17:16], exp[15:0]);
      end
    end
  endtask

  // Drive one cycle of vector v and check the selected DUT.
  task automatic step(input vec_t v, input bit sel);
    @(posedge Clk);
    #1;
    drive(v);
    exp_q.push_back({v.st, v.fa, v.fb, v.cnt});
    @(negedge Clk);
    check(v.name, sel);
  endtask

  vec_t tbl[24];
  vec_t v;
  localparam logic [1:0] RF = 2'b00, MEM = 2'b10, WB = 2'b01;

  initial begin
    // Forwarding-mode table for dut_a. Each row is one cycle. The ID
    // instruction of row k is the EX consumer of row k+1.
    //               name            rs rt urs urt fl wr rw mr  st fa   fb   cnt
    tbl[0]  = mk("ex_fwd_prod",     5, 0, 1, 0, 0, 5, 1, 0,  0, RF,  RF,  0);
    tbl[1]  = mk("ex_fwd_use",      0, 0, 0, 0, 0, 0, 0, 0,  0, MEM, RF,  0);
    tbl[2]  = mk("ex_fwd_after",    0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  RF,  0);
    tbl[3]  = mk("wb_old_prod",     0, 0, 0, 0, 0, 7, 1, 0,  0, RF,  RF,  0);
    tbl[4]  = mk("wb_new_prod",     0, 7, 0, 1, 0, 7, 1, 0,  0, RF,  RF,  0);
    tbl[5]  = mk("mem_priority",    0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  MEM, 0);
    tbl[6]  = mk("wb_only_prod",    0, 0, 0, 0, 0, 7, 1, 0,  0, RF,  RF,  0);
    tbl[7]  = mk("wb_only_id",      0, 7, 0, 1, 0, 0, 0, 0,  0, RF,  RF,  0);
    tbl[8]  = mk("wb_only_use",     0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  WB,  0);
    tbl[9]  = mk("load_use_stall",  0, 9, 0, 1, 0, 9, 1, 1,  1, RF,  RF,  0);
    tbl[10] = mk("load_use_bubble", 0, 9, 0, 1, 0, 0, 0, 0,  0, RF,  RF,  1);
    // The stall bubble sits in MEM, so by the time the consumer reaches EX
    // the load itself is in WB.
    tbl[11] = mk("load_use_fwd",    0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  WB,  1);
    tbl[12] = mk("r0_load",         0, 0, 1, 0, 0, 0, 1, 1,  0, RF,  RF,  1);
    tbl[13] = mk("flush_hit",       9, 0, 1, 0, 1, 9, 1, 1,  0, RF,  RF,  1);
    tbl[14] = mk("unused_src",      9, 9, 0, 0, 0, 9, 1, 1,  0, RF,  RF,  1);
    tbl[15] = mk("unused_after",    0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  RF,  1);
    tbl[16] = mk("load_use_rs",     4, 0, 1, 0, 0, 4, 1, 1,  1, RF,  RF,  1);
    tbl[17] = mk("load_rs_bubble",  0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  RF,  2);
    tbl[18] = mk("r0_alu_prod",     0, 0, 1, 0, 0, 0, 1, 0,  0, RF,  RF,  2);
    tbl[19] = mk("r0_alu_use",      0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  RF,  2);
    tbl[20] = mk("dual_prod_old",   0, 0, 0, 0, 0, 6, 1, 0,  0, RF,  RF,  2);
    tbl[21] = mk("dual_prod_new",   6, 8, 1, 1, 0, 8, 1, 0,  0, RF,  RF,  2);
    tbl[22] = mk("dual_use",        0, 0, 0, 0, 0, 0, 0, 0,  0, WB,  MEM, 2);
    tbl[23] = mk("dual_after",      0, 0, 0, 0, 0, 0, 0, 0,  0, RF,  RF,  2);

    // Reset with random inputs: both DUTs must be quiet.
    drive_random();
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      drive_random();
      exp_q.push_back(21'd0);
      exp_q.push_back(21'd0);
      @(negedge Clk);
      check("reset_a", 1'b0);
      check("reset_b", 1'b1);
    end
    drive_idle();
    #1 Reset_n = 1'b1;
    v = mk("post_reset_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, RF, RF, 0);
    step(v, 1'b0);

    // Forwarding table on dut_a.
    for (int i = 0; i < 24; i++) step(tbl[i], 1'b0);

    // Interlock mode on dut_b, starting from a fresh reset.
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    drive_idle();
    @(negedge Clk);
    Reset_n = 1'b1;
    step(mk("b_post_reset",   0, 0, 0, 0, 0, 0, 0, 0,  0, RF, RF, 0), 1'b1);
    step(mk("b_ex_hit",       3, 0, 1, 0, 0, 3, 1, 0,  1, RF, RF, 0), 1'b1);
    step(mk("b_mem_hit",      3, 0, 1, 0, 0, 0, 0, 0,  1, RF, RF, 1), 1'b1);
    step(mk("b_wb_clear",     3, 0, 1, 0, 0, 0, 0, 0,  0, RF, RF, 2), 1'b1);
    step(mk("b_consumer_ex",  0, 0, 0, 0, 0, 0, 0, 0,  0, RF, RF, 2), 1'b1);
    step(mk("b_flush_ex_hit", 3, 0, 1, 0, 1, 3, 1, 0,  0, RF, RF, 2), 1'b1);
    // Back-to-back ALU producers to r3: with no forwarding, the first consumer
    // sees a MEM hit and a WB hit and still gets fwd 00.
    step(mk("b_prod_r3",      0, 0, 0, 0, 0, 3, 1, 0,  0, RF, RF, 2), 1'b1);
    // Hold a permanent EX hit so that the 3-bit counter saturates at 7.
    for (int i = 0; i < 8; i++) begin
      v = mk("b_saturate", 3, 3, 1, 1, 0, 3, 1, 0, 1, RF, RF,
             16'((2 + i) > 7 ? 7 : (2 + i)));
      step(v, 1'b1);
    end

    // Reset asserted in the middle of a stall: stall and counter clear at once.
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    exp_q.push_back(21'd0);
    check("b_async_reset", 1'b1);
    drive_idle();
    @(negedge Clk);
    Reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
